// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch stage.
package rv32i_fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned DEFAULT_ADDR_W = 12;

    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [INSTR_W-1:0]        RV32I_NOP        = 32'h0000_0013;

    // Prefetch FIFO entry at the default address width.
    typedef struct packed {
        logic [INSTR_W-1:0]        instr;
        logic [DEFAULT_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer with synchronous flush and same-cycle push/pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop & (count != '0);
        do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        head  = mem[rd_ptr];
        valid = (count != '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, tracks one outstanding ROM read
// and feeds a prefetch FIFO that the consumer drains over valid/ready.
module fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_inst,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight_v;
    logic [ADDR_W-1:0]  target_pc;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               fifo_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [OCC_W-1:0]   occupancy;

    // Issue only if every slot (queued + outstanding - leaving) still fits.
    always_comb begin
        target_pc  = i_redirect_pc & ~ADDR_W'(3);
        pop        = fifo_valid & i_ready & ~i_redirect;
        push       = inflight_v & ~i_redirect;
        occupancy  = OCC_W'(count) + OCC_W'(inflight_v) - OCC_W'(pop);
        issue      = i_redirect | (occupancy < OCC_W'(DEPTH));
        o_rom_addr = i_redirect ? target_pc : fetch_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else if (i_redirect) begin
            fetch_pc    <= target_pc + ADDR_W'(4);
            inflight_v  <= 1'b1;
            inflight_pc <= target_pc;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + ADDR_W'(4);
            inflight_v  <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight_v  <= 1'b0;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data ({i_rom_inst, inflight_pc}),
        .pop       (pop),
        .flush     (i_redirect),
        .count     (count),
        .head      (head),
        .valid     (fifo_valid)
    );

    // Empty FIFO presents a NOP at PC 0.
    always_comb begin
        o_valid = fifo_valid;
        o_instr = fifo_valid ? head[ENTRY_W-1 -: INSTR_W] : RV32I_NOP;
        o_pc    = fifo_valid ? head[ADDR_W-1:0] : '0;
    end

endmodule
